e48_seq: RTL

E48_SEQ -- requirements
Module: e48_seq

---
 rtl/e48_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/e48_seq.sv
// rtl/e48_seq.sv - EEPROM read sequencer arbitrating boot and host requests onto an SPI shifter
//
// Purpose: grants one of two read requesters. For the granted requester it issues
//          select, read command 0x03, the start address, len data shifts, then deselect.
//          It returns each received byte on rd_data/rd_valid and pulses done.
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-low reset
//   boot_req/addr/len          requester 0 (MAC fetch), level request held until done
//   host_req/addr/len          requester 1 (CPU read), level request held until done
//   operation, tx_byte         command to SPI shifter (0 idle, 3 select, 1 shift, 2 deselect)
//   spi_done, rx_byte          shifter completion pulse and received byte
//   rd_data, rd_valid          one received data byte per DATA shift
//   owner, done, err           granted requester (0 boot, 1 host), end pulse, timeout pulse
// Build option: E48_SEQ_TIMEOUT_EN adds an 8-bit wait counter that aborts a stalled command.

module e48_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       boot_req,
    input  logic       host_req,
    input  logic [7:0] boot_addr,
    input  logic [7:0] host_addr,
    input  logic [2:0] boot_len,
    input  logic [2:0] host_len,
    output logic [1:0] operation,
    output logic [7:0] tx_byte,
    input  logic       spi_done,
    input  logic [7:0] rx_byte,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       owner,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_DESEL,
        S_FIN
    } state_t;

    localparam logic [1:0] OP_IDLE   = 2'd0;
    localparam logic [1:0] OP_SHIFT  = 2'd1;
    localparam logic [1:0] OP_DESEL  = 2'd2;
    localparam logic [1:0] OP_SELECT = 2'd3;
    localparam logic [7:0] READ_CMD  = 8'h03;

    state_t     state;
    logic [7:0] addr_q;
    logic [3:0] byte_cnt;
    logic       host_prio;     // 1: host wins the next tie

    logic       grant_host;
    logic [2:0] grant_len;
    logic       waiting;
    logic       accept;

    // A tie goes to whichever requester was not granted last.
    assign grant_host = host_req & (~boot_req | host_prio);
    assign grant_len  = grant_host ? host_len : boot_len;

    // operation is nonzero only in the issue cycle of a command; a spi_done
    // seen in that same cycle belongs to an older command and is ignored.
    assign waiting = (operation == OP_IDLE);
    assign accept  = waiting & spi_done;

`ifdef E48_SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timeout;

    assign timeout = waiting && !spi_done && (wait_cnt == 8'hFF)
                     && (state != S_IDLE) && (state != S_FIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 8'd0;
        end else if (operation != OP_IDLE || state == S_IDLE || state == S_FIN) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    logic timeout;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            operation <= OP_IDLE;
            tx_byte   <= 8'h00;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
            owner     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            addr_q    <= 8'h00;
            byte_cnt  <= 4'd0;
            host_prio <= 1'b0;
        end else begin
            operation <= OP_IDLE;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (boot_req || host_req) begin
                        state     <= S_SEL;
                        operation <= OP_SELECT;
                        tx_byte   <= 8'h00;
                        owner     <= grant_host;
                        addr_q    <= grant_host ? host_addr : boot_addr;
                        // len 0 encodes a full 8-byte read
                        byte_cnt  <= {(grant_len == 3'd0), grant_len};
                        host_prio <= ~grant_host;
                    end
                end
                S_SEL: begin
                    if (accept) begin
                        state     <= S_CMD;
                        operation <= OP_SHIFT;
                        tx_byte   <= READ_CMD;
                    end
                end
                S_CMD: begin
                    if (accept) begin
                        state     <= S_ADDR;
                        operation <= OP_SHIFT;
                        tx_byte   <= addr_q;
                    end
                end
                S_ADDR: begin
                    if (accept) begin
                        state     <= S_DATA;
                        operation <= OP_SHIFT;
                        tx_byte   <= 8'h00;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        rd_data  <= rx_byte;
                        rd_valid <= 1'b1;
                        byte_cnt <= byte_cnt - 4'd1;
                        tx_byte  <= 8'h00;
                        if (byte_cnt == 4'd1) begin
                            state     <= S_DESEL;
                            operation <= OP_DESEL;
                        end else begin
                            operation <= OP_SHIFT;
                        end
                    end
                end
                S_DESEL: begin
                    if (accept) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // A stalled command still ends with deselect and done so the
            // requester is always released.
            if (timeout) begin
                err <= 1'b1;
                if (state == S_DESEL) begin
                    state <= S_FIN;
                    done  <= 1'b1;
                end else begin
                    state     <= S_DESEL;
                    operation <= OP_DESEL;
                    tx_byte   <= 8'h00;
                end
            end
        end
    end

endmodule
